// File: rtl/lane_pattern_scanner.sv
// lane_pattern_scanner: builds a lane pattern from an index mask and streams it
// out one lane per beat, group-major, with a per-scan data transform.
module lane_pattern_scanner #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int OFF_W = 4,
  localparam int IW = $clog2(WIDTH),
  localparam int GW = (WIDTH / GROUP > 1) ? $clog2(WIDTH / GROUP) : 1,
  localparam int BW = (GROUP > 1) ? $clog2(GROUP) : 1,
  localparam int DW = OFF_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IW-1:0]    mask,
  input  logic [1:0]       mode,
  input  logic [OFF_W-1:0] offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_index,
  output logic [GW-1:0]    out_group,
  output logic [BW-1:0]    out_bit,
  output logic [DW-1:0]    out_data,
  output logic             first_lane,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0]    mask_q;
  logic [1:0]       mode_q;
  logic [OFF_W-1:0] off_q;
  logic [GW-1:0]    grp_q;
  logic [BW-1:0]    bit_q;
  logic             p, np, last, wrap;
  always_comb begin
    pat_d = '0;
    for (int n = 0; n < WIDTH; n++) pat_d[n] = |(IW'(n) & mask_q);
  end
  assign out_index  = IW'(32'(grp_q) * GROUP + 32'(bit_q));
  assign out_group  = grp_q;
  assign out_bit    = bit_q;
  assign out_valid  = state_q == SCAN;
  assign busy       = state_q == LOAD || state_q == SCAN;
  assign done       = state_q == DONE;
  assign first_lane = pat_q[0];
  assign p          = pat_q[out_index];
  assign np         = ~p;
  assign last       = out_index == IW'(WIDTH - 1);
  assign wrap       = bit_q == BW'(GROUP - 1);
  // np is a named 1-bit net so the size casts zero-extend the complement
  // rather than complementing an already-widened value.
  always_comb
    out_data = mode_q == 2'd0 ? DW'(p) :
               mode_q == 2'd1 ? DW'(np) :
               mode_q == 2'd2 ? DW'(np) + DW'(off_q) : DW'({p, np});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      off_q   <= '0;
      grp_q   <= '0;
      bit_q   <= '0;
    end else if (abort && busy) begin
      state_q <= IDLE;
      grp_q   <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mask_q  <= mask;
          mode_q  <= mode;
          off_q   <= offset;
          state_q <= LOAD;
        end
        LOAD: begin
          pat_q   <= pat_d;
          grp_q   <= '0;
          bit_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: if (out_ready) begin
          if (last) begin
            grp_q   <= '0;
            bit_q   <= '0;
            state_q <= DONE;
          end else begin
            bit_q <= wrap ? '0 : bit_q + 1'b1;
            grp_q <= wrap ? grp_q + 1'b1 : grp_q;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_pattern_scanner.sv
// tb_lane_pattern_scanner: directed checks of a 32x8 scanner plus a 16x1 instance.
module tb_lane_pattern_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, abort, out_ready, out_valid, first_lane, busy, done;
  logic [4:0] mask, out_index, out_data;
  logic [1:0] mode, out_group;
  logic [3:0] offset;
  logic [2:0] out_bit;

  logic       b_start, b_ready, b_valid, b_first, b_busy, b_done;
  logic [3:0] b_mask, b_index, b_group;
  logic [0:0] b_bit;
  logic [4:0] b_data;

  int checks = 0;
  int errors = 0;

  lane_pattern_scanner #(.WIDTH(32), .GROUP(8), .OFF_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask),
    .mode(mode), .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_group(out_group), .out_bit(out_bit),
    .out_data(out_data), .first_lane(first_lane), .busy(busy), .done(done)
  );

  lane_pattern_scanner #(.WIDTH(16), .GROUP(1), .OFF_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0), .mask(b_mask),
    .mode(2'd0), .offset(4'd0), .out_valid(b_valid), .out_ready(b_ready),
    .out_index(b_index), .out_group(b_group), .out_bit(b_bit),
    .out_data(b_data), .first_lane(b_first), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int n, input int m, input int md, input int off);
    int p;
    p = ((n & m) != 0) ? 1 : 0;
    return md == 0 ? p : md == 1 ? 1 - p : md == 2 ? 1 - p + off : p * 2 + (1 - p);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input int m, input int md, input int off, input int stall_pct, input bit hold);
    int n, cyc;
    mask = 5'(m); mode = 2'(md); offset = 4'(off); start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_valid", out_valid, 0);
    tick;
    n = 0; cyc = 0;
    while (n < 32 && cyc < 1000) begin
      out_ready = $urandom_range(0, 99) >= stall_pct;
      chk("valid", out_valid, 1);
      chk("index", out_index, n);
      chk("group", out_group, n / 8);
      chk("bit", out_bit, n % 8);
      chk("data", out_data, model(n, m, md, off));
      chk("done_early", done, 0);
      if (out_ready) n++;
      cyc++;
      tick;
    end
    chk("beats", n, 32);
    chk("done", done, 1);
    chk("done_valid", out_valid, 0);
    out_ready = 1'b1;
    tick;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    start = 1'b0;
    if (hold) begin
      tick;
      chk("no_restart", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp16;
    exp16 = 16'hFCFC;
    start = 0; abort = 0; out_ready = 1; mask = 0; mode = 0; offset = 0;
    b_start = 0; b_ready = 1; b_mask = 0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_group", out_group, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_first", first_lane, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #10 rst_n = 1'b1;
    tick;
    chk("idle_busy0", busy, 0);

    run_scan(1, 0, 0, 0, 0);
    chk("first_lane", first_lane, 0);
    run_scan(1, 2, 11, 0, 0);
    run_scan(1, 3, 0, 0, 0);
    run_scan(5'h13, 1, 0, 40, 0);
    run_scan(5'h0A, 2, 15, 40, 0);
    run_scan(0, 0, 0, 0, 0);

    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("idle_abort", busy, 0);

    mask = 5'd3; mode = 2'd0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int i = 0; i < 9; i++) tick;
    chk("pre_abort_idx", out_index, 9);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_index", out_index, 0);
    tick;
    chk("abort_no_done", done, 0);
    run_scan(3, 0, 0, 0, 0);

    run_scan(1, 0, 0, 0, 1);

    mask = 5'd7; mode = 2'd1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    chk("mid_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_index", out_index, 0);
    chk("arst_group", out_group, 0);
    chk("arst_bit", out_bit, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_first", first_lane, 0);
    #10 rst_n = 1'b1;
    tick;

    b_mask = 4'b0110; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("b_load", b_busy, 1);
    tick;
    for (int n = 0; n < 16; n++) begin
      chk("b_valid", b_valid, 1);
      chk("b_index", b_index, n);
      chk("b_group", b_group, n);
      chk("b_bit", b_bit, 0);
      chk("b_data", b_data, 32'(exp16[n]));
      tick;
    end
    chk("b_done", b_done, 1);
    chk("b_first", b_first, 0);
    tick;
    chk("b_done_pulse", b_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
